dom_and_sched: RTL and testbench
================================

# dom_and_sched

Sequencer and two-port arbiter for the third-order DOM AND gadget (4 shares, 6 randomness words). It accepts masked operand pairs from two requesters with round-robin arbitration, and consumes one fresh randomness bundle per operation from a handshaked RNG stream. It drives the gadget through its two-cycle evaluation window and returns the four output shares with the requester id. It sits between the masked datapath requesters and a single shared `dom_and_3rdorder` instance.

## Interface
- `WIDTH`, default 8: bit width of each share and of each randomness word.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req0_valid_i` in 1: requester 0 operand valid.
- `req0_ready_o` out 1: requester 0 accept.
- `req0_x_i` in 4*WIDTH: X shares, share k at bits [k*WIDTH +: WIDTH].
- `req0_y_i` in 4*WIDTH: Y shares, same packing.
- `req1_valid_i`, `req1_ready_o`, `req1_x_i`, `req1_y_i`: as for requester 0.
- `rnd_valid_i` in 1: randomness bundle valid.
- `rnd_ready_o` out 1: randomness consumed.
- `rnd_i` in 6*WIDTH: Z0..Z5, Zk at [k*WIDTH +: WIDTH].
- `g_rst_o` out 1: gadget synchronous reset, active-high.
- `g_x_o` out 4*WIDTH: gadget X shares.
- `g_y_o` out 4*WIDTH: gadget Y shares.
- `g_z_o` out 6*WIDTH: gadget Z words.
- `g_q_i` in 4*WIDTH: gadget Q shares.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result accepted.
- `res_q_o` out 4*WIDTH: result shares.
- `res_id_o` out 1: requester id of the result.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, LOAD, EVAL, OUT.
- IDLE:
  - A grant occurs when `rnd_valid_i`=1 and at least one `reqN_valid_i`=1.
  - If both requesters are valid, the winner is the one not granted last. The priority pointer resets to requester 0 and toggles to the other requester after every grant.
  - On a grant, `reqW_ready_o`=1 and `rnd_ready_o`=1 in the same cycle (combinational). Operands, Z and id are registered. Next state is LOAD.
  - With no randomness available, all ready outputs stay 0; no operand is accepted without fresh Z.
- LOAD:
  - `g_x_o`/`g_y_o`/`g_z_o` are driven from the registers and `g_rst_o`=0.
  - The gadget captures its masked cross terms at the end of the cycle.
  - Next state is EVAL.
- EVAL:
  - `g_x_o`/`g_y_o` are held, `g_z_o`=0 and `g_rst_o`=1, so the gadget's cross registers clear instead of latching unmasked products.
  - `g_q_i` is captured into the result register.
  - The operand and Z registers clear to 0 at the end of the cycle.
  - Next state is OUT.
- OUT:
  - `res_valid_o`=1, and `res_q_o`/`res_id_o` are stable until the handshake.
  - On `res_ready_i`=1, the result register clears and next state is IDLE.
  - No new grant is issued in OUT.
- Outside LOAD and EVAL, `g_x_o`, `g_y_o` and `g_z_o` are all-zero. `g_rst_o`=1 in every state except LOAD.
- No arithmetic is performed on shares; every share path is a pure register or mux. No share is ever XOR-combined with another share.

## Timing
- Reset values (asynchronous, while `rst_ni`=0):
  - FSM=IDLE, priority pointer=0.
  - All ready outputs=0.
  - `res_valid_o`=0; `res_q_o`, `res_id_o`, `g_x_o`, `g_y_o`, `g_z_o` all 0.
  - `g_rst_o`=1, `busy_o`=0.
- Latency: accept at cycle T (IDLE) → LOAD at T+1 → EVAL at T+2 → `res_valid_o`=1 at T+3.
- Throughput: with `res_ready_i` held at 1 and inputs always valid, the next accept occurs at T+4 (one op per 4 cycles).
- Backpressure: OUT is held indefinitely while `res_ready_i`=0; requesters and the RNG see ready=0 throughout.
- Requesters and the RNG must hold valid and data stable until accepted. The block tolerates valid dropping before acceptance and never consumes a partial handshake.
- Simultaneous requests in one cycle: exactly one grant. Over N back-to-back cycles with both requesters valid, grants alternate 0,1,0,1…
- `rnd_valid_i` deasserting while requests are pending: the grant is deferred and the pointer is unchanged.
- Reset mid-operation (any state): immediate return to reset values; the in-flight result is discarded and no ready is asserted during reset.
- After reset release, the first grant is possible in the first clock edge cycle with `rst_ni`=1.

## Test plan
- Single op, requester 0:
  - Stimulus: X shares A5,3C,0F,F0 (x=0x66); Y shares 12,34,56,7E (y=0x0E); random Z.
  - Required: `res_valid_o` at T+3, `res_id_o`=0, XOR of the `res_q_o` shares = 0x06.
  - Repeat for 1000 random operand/Z sets against x&y.
- Arbitration: both requesters valid continuously, `res_ready_i`=1.
  - Required: grants alternate 0,1,0,1 with one accept every 4 cycles.
  - With only requester 1 valid: consecutive grants to 1.
- Randomness starvation: requests valid, `rnd_valid_i`=0 for 10 cycles.
  - Required: no ready asserted and `busy_o`=0.
  - When `rnd_valid_i` rises: grant that cycle with `rnd_ready_o`=1.
- Backpressure: `res_ready_i`=0 for 7 cycles in OUT.
  - Required: `res_q_o`/`res_id_o` stable, no new accept.
  - Accept on the cycle after `res_ready_i` is released.
- Masking hygiene, checked every cycle:
  - `g_z_o`=0 and `g_x_o`/`g_y_o`=0 outside LOAD/EVAL.
  - `g_rst_o`=0 only in LOAD.
  - Gadget cross registers = 0 after every EVAL.
- Reset in EVAL: drop `rst_ni` asynchronously mid-cycle.
  - Required: all outputs immediately take their reset values, no `res_valid_o` follows, and the next op after release is granted to requester 0.

Source files
------------

// File: rtl/dom_and_sched_if.sv
// Handshake and gadget bus between dom_and_sched, its two requesters, the RNG
// stream and the shared third-order DOM AND gadget.
interface dom_and_sched_if #(
   parameter int WIDTH = 8
);
   logic                 req0_valid_i;
   logic                 req0_ready_o;
   logic [4*WIDTH-1:0]   req0_x_i;
   logic [4*WIDTH-1:0]   req0_y_i;
   logic                 req1_valid_i;
   logic                 req1_ready_o;
   logic [4*WIDTH-1:0]   req1_x_i;
   logic [4*WIDTH-1:0]   req1_y_i;
   logic                 rnd_valid_i;
   logic                 rnd_ready_o;
   logic [6*WIDTH-1:0]   rnd_i;
   logic                 g_rst_o;
   logic [4*WIDTH-1:0]   g_x_o;
   logic [4*WIDTH-1:0]   g_y_o;
   logic [6*WIDTH-1:0]   g_z_o;
   logic [4*WIDTH-1:0]   g_q_i;
   logic                 res_valid_o;
   logic                 res_ready_i;
   logic [4*WIDTH-1:0]   res_q_o;
   logic                 res_id_o;
   logic                 busy_o;

   modport slave (
      input  req0_valid_i, req0_x_i, req0_y_i,
      input  req1_valid_i, req1_x_i, req1_y_i,
      input  rnd_valid_i, rnd_i, g_q_i, res_ready_i,
      output req0_ready_o, req1_ready_o, rnd_ready_o,
      output g_rst_o, g_x_o, g_y_o, g_z_o,
      output res_valid_o, res_q_o, res_id_o, busy_o
   );

   modport master (
      output req0_valid_i, req0_x_i, req0_y_i,
      output req1_valid_i, req1_x_i, req1_y_i,
      output rnd_valid_i, rnd_i, g_q_i, res_ready_i,
      input  req0_ready_o, req1_ready_o, rnd_ready_o,
      input  g_rst_o, g_x_o, g_y_o, g_z_o,
      input  res_valid_o, res_q_o, res_id_o, busy_o
   );
endinterface

// File: rtl/dom_and_sched.sv
// Round-robin sequencer for a shared third-order DOM AND gadget: one operand
// pair plus one fresh randomness bundle per op, LOAD/EVAL window, result out.
module dom_and_sched #(
   parameter int WIDTH = 8
) (
   input logic            clk_i,
   input logic            rst_ni,
   dom_and_sched_if.slave bus
);
   localparam int SW = 4 * WIDTH;
   localparam int ZW = 6 * WIDTH;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] EVAL = 2'd2;
   localparam logic [1:0] OUT  = 2'd3;

   logic [1:0]    state;
   logic          ptr;
   logic [SW-1:0] x_r, y_r, q_r;
   logic [ZW-1:0] z_r;
   logic          id_r;
   logic          grant, win;

   // Gated by rst_ni so no ready can leak out while reset is held.
   assign grant = rst_ni && (state == IDLE) && bus.rnd_valid_i &&
                  (bus.req0_valid_i || bus.req1_valid_i);
   assign win   = (bus.req0_valid_i && bus.req1_valid_i) ? ptr : bus.req1_valid_i;

   assign bus.req0_ready_o = grant && !win;
   assign bus.req1_ready_o = grant && win;
   assign bus.rnd_ready_o  = grant;

   // Z reaches the gadget only in LOAD; in EVAL it is zeroed and the gadget
   // reset clears the cross registers instead of latching unmasked products.
   assign bus.g_x_o   = (state == LOAD || state == EVAL) ? x_r : '0;
   assign bus.g_y_o   = (state == LOAD || state == EVAL) ? y_r : '0;
   assign bus.g_z_o   = (state == LOAD) ? z_r : '0;
   assign bus.g_rst_o = (state != LOAD);

   assign bus.res_valid_o = (state == OUT);
   assign bus.res_q_o     = q_r;
   assign bus.res_id_o    = (state == OUT) && id_r;
   assign bus.busy_o      = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         ptr   <= 1'b0;
         x_r   <= '0;
         y_r   <= '0;
         z_r   <= '0;
         q_r   <= '0;
         id_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (grant) begin
               x_r   <= win ? bus.req1_x_i : bus.req0_x_i;
               y_r   <= win ? bus.req1_y_i : bus.req0_y_i;
               z_r   <= bus.rnd_i;
               id_r  <= win;
               ptr   <= !win;
               state <= LOAD;
            end
            LOAD: state <= EVAL;
            EVAL: begin
               q_r   <= bus.g_q_i;
               x_r   <= '0;
               y_r   <= '0;
               z_r   <= '0;
               state <= OUT;
            end
            OUT: if (bus.res_ready_i) begin
               q_r   <= '0;
               id_r  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dom_and_sched.sv
// Bench for dom_and_sched with a behavioural third-order DOM AND gadget and a
// share-level reference (XOR of result shares must equal x&y).
module tb_dom_and_sched;
   localparam int W  = 8;
   localparam int SW = 4 * W;
   localparam int ZW = 6 * W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dom_and_sched_if #(.WIDTH(W)) bus ();
   dom_and_sched #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic prio = 1'b0;
   logic [SW-1:0] xd [2];
   logic [SW-1:0] yd [2];
   logic [ZW-1:0] zd;

   // Gadget: cross term (i,j) = x_i&y_j ^ Z(pair), registered; Q_i = x_i&y_i ^ crosses.
   logic [W-1:0] cr [4][4];
   function automatic int pidx(input int i, input int j);
      int lo, hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return (lo == 0) ? hi - 1 : (lo == 1) ? hi + 1 : 5;
   endfunction

   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (bus.g_rst_o || i == j) cr[i][j] <= '0;
            else cr[i][j] <= (bus.g_x_o[i*W +: W] & bus.g_y_o[j*W +: W]) ^ bus.g_z_o[pidx(i, j)*W +: W];

   always_comb begin
      bus.g_q_i = '0;
      for (int i = 0; i < 4; i++) begin
         bus.g_q_i[i*W +: W] = bus.g_x_o[i*W +: W] & bus.g_y_o[i*W +: W];
         for (int j = 0; j < 4; j++)
            if (j != i) bus.g_q_i[i*W +: W] = bus.g_q_i[i*W +: W] ^ cr[i][j];
      end
   end

   function automatic logic [W-1:0] xor4(input logic [SW-1:0] v);
      return v[0 +: W] ^ v[W +: W] ^ v[2*W +: W] ^ v[3*W +: W];
   endfunction

   function automatic logic cross_any();
      logic a = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) a = a | (|cr[i][j]);
      return a;
   endfunction

   task automatic drive();
      bus.req0_x_i = xd[0]; bus.req0_y_i = yd[0];
      bus.req1_x_i = xd[1]; bus.req1_y_i = yd[1];
      bus.rnd_i = zd;
   endtask

   task automatic randomize_all();
      for (int k = 0; k < 2; k++) begin
         xd[k] = SW'($urandom);
         yd[k] = SW'($urandom);
      end
      zd = ZW'({$urandom, $urandom});
      drive();
   endtask

   // One full operation starting in IDLE; stall = OUT cycles with res_ready low.
   task automatic do_op(input logic v0, input logic v1, input int stall,
                        output logic id, output logic [SW-1:0] q);
      logic [SW-1:0] ex, ey;
      logic [ZW-1:0] ez;
      logic [W-1:0]  eq;
      bus.req0_valid_i = v0; bus.req1_valid_i = v1;
      bus.rnd_valid_i = 1'b1; bus.res_ready_i = 1'b0;
      drive();
      #1;
      id = (v0 && v1) ? prio : v1;
      chk_cnt++;
      if ({bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o, bus.busy_o} !== {!id, id, 1'b1, 1'b0})
         $display("FAIL grant: r0/r1/rnd/busy=%b required %b",
                  {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o, bus.busy_o}, {!id, id, 1'b1, 1'b0});
      else pass_cnt++;
      ex = xd[id]; ey = yd[id]; ez = zd;
      eq = xor4(ex) & xor4(ey);
      prio = !id;
      @(negedge clk);
      xd[id] = SW'($urandom); yd[id] = SW'($urandom); zd = ZW'({$urandom, $urandom});
      if (id) bus.req1_valid_i = 1'b0; else bus.req0_valid_i = 1'b0;
      drive();
      #1;
      chk_cnt++;
      if ({bus.g_rst_o, bus.g_x_o, bus.g_y_o, bus.g_z_o, bus.req0_ready_o, bus.req1_ready_o,
           bus.rnd_ready_o, bus.res_valid_o, bus.busy_o} !== {1'b0, ex, ey, ez, 4'b0, 1'b1})
         $display("FAIL load: rst=%b x=%h y=%h z=%h required rst=0 x=%h y=%h z=%h",
                  bus.g_rst_o, bus.g_x_o, bus.g_y_o, bus.g_z_o, ex, ey, ez);
      else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++;
      if ({bus.g_rst_o, bus.g_x_o, bus.g_y_o, bus.g_z_o, bus.res_valid_o, bus.busy_o} !==
          {1'b1, ex, ey, {ZW{1'b0}}, 1'b0, 1'b1})
         $display("FAIL eval: rst=%b x=%h y=%h z=%h vld=%b required rst=1 x=%h y=%h z=0 vld=0",
                  bus.g_rst_o, bus.g_x_o, bus.g_y_o, bus.g_z_o, bus.res_valid_o, ex, ey);
      else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++;
      if ({bus.res_valid_o, bus.res_id_o, bus.g_rst_o, bus.g_x_o, bus.g_y_o, bus.g_z_o,
           bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o} !==
          {1'b1, id, 1'b1, {SW{1'b0}}, {SW{1'b0}}, {ZW{1'b0}}, 3'b0})
         $display("FAIL out_state: vld=%b id=%b rst=%b gx=%h gz=%h required vld=1 id=%b rst=1 gx=0 gz=0",
                  bus.res_valid_o, bus.res_id_o, bus.g_rst_o, bus.g_x_o, bus.g_z_o, id);
      else pass_cnt++;
      chk_cnt++;
      if (xor4(bus.res_q_o) !== eq)
         $display("FAIL result: xor(q)=%h required %h (q=%h)", xor4(bus.res_q_o), eq, bus.res_q_o);
      else pass_cnt++;
      chk_cnt++;
      if (cross_any() !== 1'b0) $display("FAIL cross_clear: gadget cross regs nonzero, required 0");
      else pass_cnt++;
      q = bus.res_q_o;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         chk_cnt++;
         if ({bus.res_valid_o, bus.res_q_o, bus.res_id_o, bus.req0_ready_o, bus.req1_ready_o,
              bus.rnd_ready_o, bus.busy_o} !== {1'b1, q, id, 3'b0, 1'b1})
            $display("FAIL stall: vld=%b q=%h id=%b rdy=%b required vld=1 q=%h id=%b rdy=000",
                     bus.res_valid_o, bus.res_q_o, bus.res_id_o,
                     {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o}, q, id);
         else pass_cnt++;
      end
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      bus.res_ready_i = 1'b0;
      #1;
      chk_cnt++;
      if ({bus.res_valid_o, bus.res_q_o, bus.busy_o} !== {1'b0, {SW{1'b0}}, 1'b0})
         $display("FAIL release: vld=%b q=%h busy=%b required 0,0,0", bus.res_valid_o, bus.res_q_o, bus.busy_o);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1; bus.rnd_valid_i = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         chk_cnt++;
         if ({bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o, bus.res_valid_o, bus.busy_o,
              bus.g_rst_o, bus.res_id_o, bus.res_q_o, bus.g_x_o, bus.g_y_o, bus.g_z_o} !==
             {6'b000001, 1'b0, {SW{1'b0}}, {SW{1'b0}}, {SW{1'b0}}, {ZW{1'b0}}})
            $display("FAIL reset: rdy=%b vld=%b busy=%b grst=%b q=%h",
                     {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o}, bus.res_valid_o,
                     bus.busy_o, bus.g_rst_o, bus.res_q_o);
         else pass_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      prio = 1'b0;
   endtask

   task automatic test_single_op();
      logic id;
      logic [SW-1:0] q;
      xd[0] = 32'hF00F_3CA5;
      yd[0] = 32'h7E56_3412;
      do_op(1'b1, 1'b0, 0, id, q);
      chk_cnt++;
      if ({bus.res_id_o, id, xor4(q)} !== {1'b0, 1'b0, 8'h06})
         $display("FAIL single_op: id=%b xor(q)=%h required id=0 xor=06", id, xor4(q));
      else pass_cnt++;
   endtask

   task automatic test_arbitration();
      logic id, last;
      logic [SW-1:0] q;
      do_op(1'b1, 1'b1, 0, last, q);
      for (int n = 0; n < 6; n++) begin
         do_op(1'b1, 1'b1, 0, id, q);
         chk_cnt++;
         if (id !== !last) $display("FAIL alternate: grant=%0d required %0d", id, !last);
         else pass_cnt++;
         last = id;
      end
      for (int n = 0; n < 3; n++) begin
         do_op(1'b0, 1'b1, 0, id, q);
         chk_cnt++;
         if (id !== 1'b1) $display("FAIL only_req1: grant=%0d required 1", id);
         else pass_cnt++;
      end
   endtask

   task automatic test_starvation();
      logic id;
      logic [SW-1:0] q;
      bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1; bus.rnd_valid_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk_cnt++;
         if ({bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o, bus.busy_o, bus.g_rst_o,
              bus.g_x_o, bus.g_y_o, bus.g_z_o} !== {5'b00001, {SW{1'b0}}, {SW{1'b0}}, {ZW{1'b0}}})
            $display("FAIL starve: rdy=%b busy=%b grst=%b required rdy=000 busy=0 grst=1",
                     {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o}, bus.busy_o, bus.g_rst_o);
         else pass_cnt++;
         @(negedge clk);
      end
      do_op(1'b1, 1'b1, 0, id, q);
   endtask

   task automatic test_backpressure();
      logic id;
      logic [SW-1:0] q;
      do_op(1'b1, 1'b1, 7, id, q);
      do_op(1'b1, 1'b1, 3, id, q);
   endtask

   task automatic test_random_ops();
      logic id;
      logic [SW-1:0] q;
      int v;
      for (int n = 0; n < 1000; n++) begin
         v = $urandom_range(1, 3);
         do_op(v[0], v[1], (n % 17 == 0) ? 2 : 0, id, q);
      end
   endtask

   task automatic test_reset_eval();
      logic id;
      logic [SW-1:0] q;
      bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b0; bus.rnd_valid_i = 1'b1; bus.res_ready_i = 1'b1;
      #1;
      chk_cnt++;
      if ({bus.req0_ready_o, bus.rnd_ready_o} !== 2'b11)
         $display("FAIL pre_reset_grant: r0/rnd=%b required 11", {bus.req0_ready_o, bus.rnd_ready_o});
      else pass_cnt++;
      @(negedge clk);
      bus.req1_valid_i = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      prio = 1'b0;
      chk_cnt++;
      if ({bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o, bus.res_valid_o, bus.busy_o,
           bus.g_rst_o, bus.res_id_o, bus.res_q_o, bus.g_x_o, bus.g_y_o, bus.g_z_o} !==
          {6'b000001, 1'b0, {SW{1'b0}}, {SW{1'b0}}, {SW{1'b0}}, {ZW{1'b0}}})
         $display("FAIL reset_eval: rdy=%b vld=%b busy=%b grst=%b gx=%h gz=%h",
                  {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o}, bus.res_valid_o,
                  bus.busy_o, bus.g_rst_o, bus.g_x_o, bus.g_z_o);
      else pass_cnt++;
      repeat (3) begin
         @(negedge clk); #1;
         chk_cnt++;
         if ({bus.res_valid_o, bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o} !== 4'b0)
            $display("FAIL reset_hold: vld=%b rdy=%b required 0 and 000", bus.res_valid_o,
                     {bus.req0_ready_o, bus.req1_ready_o, bus.rnd_ready_o});
         else pass_cnt++;
      end
      rst_n = 1'b1;
      do_op(1'b1, 1'b1, 0, id, q);
      chk_cnt++;
      if (id !== 1'b0) $display("FAIL post_reset_grant: grant=%0d required 0", id);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) cr[i][j] = '0;
      bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
      bus.rnd_valid_i = 1'b0; bus.res_ready_i = 1'b0;
      randomize_all();
      test_reset();
      test_single_op();
      test_arbitration();
      test_starvation();
      test_backpressure();
      test_random_ops();
      test_reset_eval();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
